// File: rtl/imem_fetch.sv
// Instruction storage with a valid/ready fetch port, a program-load write port and fault tagging.
// Responses go through a 2-entry queue; OUT_REG adds one register stage between storage and queue.
module imem_fetch #(
   parameter int          DEPTH     = 2048,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
   parameter bit          OUT_REG   = 1'b0,
   parameter string       INIT_FILE = "",
   localparam int         AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_data,
   output logic [1:0]    rsp_fault,
   input  logic          flush,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
);

   localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic [1:0]    fault_in;
   logic          accept;
   logic          pop;
   logic          q_valid;
   logic [1:0]    count;
   logic          inflight;
   logic [2:0]    occupancy;
   logic [31:0]   head_data;
   logic [1:0]    head_fault;

   logic [31:0]   rd_word_reg;
   logic [1:0]    rd_fault_reg;
   logic [31:0]   rd_out_data;

   // Address decode: unsigned compare on the full 33-bit offset so wrap-around is caught.
   always_comb begin
      offset      = req_addr - BASE_ADDR;
      idx         = offset[AW+1:2];
      fault_in[0] = |req_addr[1:0];
      fault_in[1] = (req_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
   end

   assign q_valid     = (count != 2'd0);
   assign pop         = q_valid && rsp_ready;
   assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign req_ready   = !rst && !ld_en && (occupancy < 3'd2);
   assign accept      = req_valid && req_ready;
   assign rd_out_data = (|rd_fault_reg) ? NOP_WORD : rd_word_reg;

   // Single-port storage: ld_en blocks accept, so a write and a read never share a cycle.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
      if (accept && fault_in == 2'b00) begin
         rd_word_reg <= mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rd_fault_reg <= fault_in;
      end
   end

   generate
      if (OUT_REG) begin : g_out_reg
         logic        p1_valid_reg;
         logic [1:0]  q_count_reg;
         logic        q_head_reg;
         logic [31:0] q_data_reg  [2];
         logic [1:0]  q_fault_reg [2];
         logic        push;
         logic [1:0]  base;
         logic        head_next;
         logic        wr_idx;

         // The read register is the pipe stage; it drains into the queue one cycle later.
         always_comb begin
            push      = p1_valid_reg && !flush;
            base      = flush ? 2'd0 : (q_count_reg - {1'b0, pop});
            head_next = flush ? 1'b0 : (q_head_reg ^ pop);
            wr_idx    = head_next ^ base[0];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               p1_valid_reg <= 1'b0;
               q_count_reg  <= 2'd0;
               q_head_reg   <= 1'b0;
            end else begin
               p1_valid_reg <= accept;
               q_count_reg  <= base + {1'b0, push};
               q_head_reg   <= head_next;
            end
         end

         always_ff @(posedge clk) begin
            if (push) begin
               q_data_reg[wr_idx]  <= rd_out_data;
               q_fault_reg[wr_idx] <= rd_fault_reg;
            end
         end

         assign count      = q_count_reg;
         assign inflight   = p1_valid_reg;
         assign head_data  = q_data_reg[q_head_reg];
         assign head_fault = q_fault_reg[q_head_reg];
      end else begin : g_direct
         logic [1:0]  q_count_reg;
         logic [31:0] skid_data_reg;
         logic [1:0]  skid_fault_reg;
         logic [1:0]  base;

         // The youngest entry always lives in the read register; an older survivor moves to the skid slot.
         always_comb begin
            base = flush ? 2'd0 : (q_count_reg - {1'b0, pop});
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               q_count_reg <= 2'd0;
            end else begin
               q_count_reg <= base + {1'b0, accept};
            end
         end

         always_ff @(posedge clk) begin
            if (accept && base == 2'd1) begin
               skid_data_reg  <= rd_out_data;
               skid_fault_reg <= rd_fault_reg;
            end
         end

         assign count      = q_count_reg;
         assign inflight   = 1'b0;
         assign head_data  = (q_count_reg == 2'd2) ? skid_data_reg  : rd_out_data;
         assign head_fault = (q_count_reg == 2'd2) ? skid_fault_reg : rd_fault_reg;
      end
   endgenerate

   assign rsp_valid = !rst && q_valid;
   assign rsp_data  = rsp_valid ? head_data  : NOP_WORD;
   assign rsp_fault = rsp_valid ? head_fault : 2'b00;

endmodule
